// File: rtl/ram_loader_pkg.sv
// Shared definitions for the instruction RAM loader.
// Contents: loader FSM state enum, word/RAM geometry constants and the
// big-endian byte-lane select used when serialising a 32-bit word.
package ram_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned RAM_BYTES      = 256;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitWord = 3'd1,
        StWrite    = 3'd2,
        StDone     = 3'd3,
        StVerify   = 3'd4
    } loader_state_e;

    // Byte index 0 selects the most significant byte (big-endian order).
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] lane;
        unique case (idx)
            2'd0: lane = word[31:24];
            2'd1: lane = word[23:16];
            2'd2: lane = word[15:8];
            2'd3: lane = word[7:0];
            default: lane = word[31:24];
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// Holds one captured instruction word and walks through its four bytes.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   capture      - load word_in, select byte 0
//   advance      - step to the next byte
//   rewind       - reselect byte 0 of the held word (readback pass)
//   word_in      - word presented by the host
//   cur_byte     - registered byte at the current index
//   last_byte    - current index is the final byte of the word
module word_byte_serializer
    import ram_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        capture,
    input  logic        advance,
    input  logic        rewind,
    input  logic [31:0] word_in,
    output logic [7:0]  cur_byte,
    output logic        last_byte
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  byte_q, byte_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        byte_d = byte_q;
        if (capture) begin
            word_d = word_in;
            idx_d  = 2'd0;
            byte_d = byte_lane(word_in, 2'd0);
        end else if (rewind) begin
            idx_d  = 2'd0;
            byte_d = byte_lane(word_q, 2'd0);
        end else if (advance) begin
            idx_d  = idx_q + 2'd1;
            byte_d = byte_lane(word_q, idx_q + 2'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
            byte_q <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
            byte_q <= byte_d;
        end
    end

    assign cur_byte  = byte_q;
    assign last_byte = (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/inst_ram_loader.sv
// Write-side loader for the byte-addressable 256x8 instruction RAM.
// Takes 32-bit words from a host over WordValid/WordReady and writes each
// one big-endian as four consecutive byte writes starting at BaseAddr.
// Ports:
//   clk, Reset             - clock, asynchronous active-low reset
//   Start, BaseAddr,
//   WordCount              - launch a load (sampled in idle only)
//   WordIn, WordValid,
//   WordReady              - host word handshake
//   MemAddr, MemData,
//   MemWE                  - RAM write port
//   Busy, Done, Wrap       - status (Wrap sticky per load)
// Optional build macro READBACK_VERIFY_EN adds MemDataIn/Mismatch and a
// four-cycle readback pass after every word.
module inst_ram_loader
    import ram_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 7
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [CNT_W-1:0]  WordCount,
    input  logic [31:0]       WordIn,
    input  logic              WordValid,
    output logic              WordReady,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [7:0]        MemData,
    output logic              MemWE,
    output logic              Busy,
    output logic              Done,
`ifdef READBACK_VERIFY_EN
    input  logic [7:0]        MemDataIn,
    output logic              Mismatch,
`endif
    output logic              Wrap
);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              mem_we_q, mem_we_d;
    logic              done_q, done_d;
    logic              wrap_q, wrap_d;

    logic       ser_capture, ser_advance, ser_rewind;
    logic       ser_last;
    logic [7:0] ser_byte;
    logic       issue_byte;
    logic       finish_word;

`ifdef READBACK_VERIFY_EN
    logic mismatch_q, mismatch_d;
`endif

    word_byte_serializer u_serializer (
        .clk       (clk),
        .rst_n     (Reset),
        .capture   (ser_capture),
        .advance   (ser_advance),
        .rewind    (ser_rewind),
        .word_in   (WordIn),
        .cur_byte  (ser_byte),
        .last_byte (ser_last)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mem_addr_d  = mem_addr_q;
        remaining_d = remaining_q;
        mem_we_d    = 1'b0;
        wrap_d      = wrap_q;
        ser_capture = 1'b0;
        ser_advance = 1'b0;
        ser_rewind  = 1'b0;
        issue_byte  = 1'b0;
        finish_word = 1'b0;
`ifdef READBACK_VERIFY_EN
        mismatch_d  = mismatch_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    addr_d      = BaseAddr;
                    remaining_d = WordCount;
                    wrap_d      = 1'b0;
`ifdef READBACK_VERIFY_EN
                    mismatch_d  = 1'b0;
`endif
                    state_d     = (WordCount == '0) ? StDone : StWaitWord;
                end
            end
            StWaitWord: begin
                // WordReady is high throughout this state.
                if (WordValid) begin
                    ser_capture = 1'b1;
                    issue_byte  = 1'b1;
                    state_d     = StWrite;
                end
            end
            StWrite: begin
                if (ser_last) begin
`ifdef READBACK_VERIFY_EN
                    // Re-address the word just written; addr_q is already past it.
                    ser_rewind = 1'b1;
                    mem_addr_d = addr_q - ADDR_W'(BYTES_PER_WORD);
                    state_d    = StVerify;
`else
                    finish_word = 1'b1;
`endif
                end else begin
                    ser_advance = 1'b1;
                    issue_byte  = 1'b1;
                end
            end
`ifdef READBACK_VERIFY_EN
            StVerify: begin
                // MemData shows the expected byte while MemAddr points at it.
                if (MemDataIn != ser_byte) begin
                    mismatch_d = 1'b1;
                end
                if (ser_last) begin
                    finish_word = 1'b1;
                end else begin
                    ser_advance = 1'b1;
                    mem_addr_d  = mem_addr_q + ADDR_W'(1);
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Launch one byte write next cycle at the current address counter.
        if (issue_byte) begin
            mem_we_d   = 1'b1;
            mem_addr_d = addr_q;
            addr_d     = addr_q + ADDR_W'(1);
            if (addr_q == ADDR_W'(RAM_BYTES - 1)) begin
                wrap_d = 1'b1;
            end
        end

        if (finish_word) begin
            remaining_d = remaining_q - CNT_W'(1);
            state_d     = (remaining_q == CNT_W'(1)) ? StDone : StWaitWord;
        end
    end

    assign done_d = (state_d == StDone);

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            remaining_q <= '0;
            mem_we_q    <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            remaining_q <= remaining_d;
            mem_we_q    <= mem_we_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
        end
    end

`ifdef READBACK_VERIFY_EN
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign Mismatch = mismatch_q;
`endif

    assign WordReady = (state_q == StWaitWord);
    assign Busy      = (state_q != StIdle);
    assign MemAddr   = mem_addr_q;
    assign MemData   = ser_byte;
    assign MemWE     = mem_we_q;
    assign Done      = done_q;
    assign Wrap      = wrap_q;

endmodule

// File: tb/tb_inst_ram_loader.sv
module tb_inst_ram_loader;

    logic        clk       = 1'b0;
    logic        Reset     = 1'b0;
    logic        Start     = 1'b0;
    logic [7:0]  BaseAddr  = '0;
    logic [6:0]  WordCount = '0;
    logic [31:0] WordIn    = '0;
    logic        WordValid = 1'b0;
    logic        WordReady;
    logic [7:0]  MemAddr;
    logic [7:0]  MemData;
    logic        MemWE;
    logic        Busy;
    logic        Done;
    logic        Wrap;

    logic [7:0] ram [256] = '{default: 8'hFF};

`ifdef READBACK_VERIFY_EN
    localparam int VerifyCyc = 4;
    logic [7:0] MemDataIn;
    logic       Mismatch;
    logic       stuck_en = 1'b0;
    assign MemDataIn = (stuck_en && MemAddr == 8'd5) ? 8'h00 : ram[MemAddr];
`else
    localparam int VerifyCyc = 0;
`endif

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    int rdy_cnt = 0;
    int we0, dn0, rd0;

    inst_ram_loader #(
        .ADDR_W (8),
        .CNT_W  (7)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .Start     (Start),
        .BaseAddr  (BaseAddr),
        .WordCount (WordCount),
        .WordIn    (WordIn),
        .WordValid (WordValid),
        .WordReady (WordReady),
        .MemAddr   (MemAddr),
        .MemData   (MemData),
        .MemWE     (MemWE),
        .Busy      (Busy),
        .Done      (Done),
`ifdef READBACK_VERIFY_EN
        .MemDataIn (MemDataIn),
        .Mismatch  (Mismatch),
`endif
        .Wrap      (Wrap)
    );

    always #5 clk = ~clk;

    // RAM model and activity counters sample the values of the cycle just ended.
    always @(posedge clk) begin
        if (MemWE) ram[MemAddr] <= MemData;
        if (MemWE) we_cnt <= we_cnt + 1;
        if (Done) done_cnt <= done_cnt + 1;
        if (WordReady) rdy_cnt <= rdy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int n = 0;
        while (Done !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, {31'd0, Done}, 32'd1);
        tick();
    endtask

    function automatic logic [31:0] ram_word(input int a);
        return {ram[a], ram[(a + 1) % 256], ram[(a + 2) % 256], ram[(a + 3) % 256]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #2;
        check("rst_addr", MemAddr, 8'h00);
        check("rst_data", MemData, 8'h00);
        check("rst_we", MemWE, 0);
        check("rst_ready", WordReady, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_wrap", Wrap, 0);
        tick();
        tick();
        Reset = 1'b1;
        tick();

        // 1. Basic load, two words
        we0 = we_cnt; dn0 = done_cnt;
        BaseAddr = 8'd0; WordCount = 7'd2; WordIn = 32'hE3A01005; WordValid = 1'b1; Start = 1'b1;
        tick();
        Start = 1'b0;
        check("t1_ready", WordReady, 1);
        check("t1_busy", Busy, 1);
        check("t1_we_wait", MemWE, 0);
        tick();
        WordIn = 32'h00000000;
        check("t1_b0_we", MemWE, 1);
        check("t1_b0_addr", MemAddr, 8'd0);
        check("t1_b0_data", MemData, 8'hE3);
        tick();
        check("t1_b1_addr", MemAddr, 8'd1);
        check("t1_b1_data", MemData, 8'hA0);
        tick();
        check("t1_b2_data", MemData, 8'h10);
        tick();
        check("t1_b3_addr", MemAddr, 8'd3);
        check("t1_b3_data", MemData, 8'h05);
        repeat (VerifyCyc) tick();
        tick();
        check("t1_gap_we", MemWE, 0);
        check("t1_gap_ready", WordReady, 1);
        check("t1_gap_hold_addr", MemAddr, 8'd3);
        check("t1_gap_hold_data", MemData, 8'h05);
        tick();
        check("t1_w1_we", MemWE, 1);
        check("t1_w1_addr", MemAddr, 8'd4);
        check("t1_w1_data", MemData, 8'h00);
        tick(); tick(); tick();
        check("t1_w1_last_addr", MemAddr, 8'd7);
        repeat (VerifyCyc) tick();
        tick();
        check("t1_done", Done, 1);
        check("t1_done_busy", Busy, 1);
        check("t1_done_we", MemWE, 0);
        tick();
        check("t1_idle_done", Done, 0);
        check("t1_idle_busy", Busy, 0);
        check("t1_we_count", we_cnt - we0, 8);
        check("t1_done_count", done_cnt - dn0, 1);
        check("t1_ram0", ram_word(0), 32'hE3A01005);
        check("t1_ram4", ram_word(4), 32'h00000000);

        // 2. Host backpressure between words
        we0 = we_cnt;
        BaseAddr = 8'd8; WordCount = 7'd2; WordIn = 32'h01020304; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        check("t2_b0_addr", MemAddr, 8'd8);
        check("t2_b0_data", MemData, 8'h01);
        WordValid = 1'b0;
        WordIn = 32'hDEADBEEF;
        tick(); tick(); tick();
        repeat (VerifyCyc) tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t2_stall_ready", WordReady, 1);
            check("t2_stall_we", MemWE, 0);
            tick();
        end
        WordValid = 1'b1;
        WordIn = 32'hA5B6C7D8;
        check("t2_pre_hs_we", MemWE, 0);
        tick();
        WordIn = 32'h12345678;
        check("t2_resume_we", MemWE, 1);
        check("t2_resume_addr", MemAddr, 8'd12);
        check("t2_resume_data", MemData, 8'hA5);
        tick();
        check("t2_b1_data", MemData, 8'hB6);
        wait_done("t2_done", 20);
        check("t2_we_count", we_cnt - we0, 8);
        check("t2_ram8", ram_word(8), 32'h01020304);
        check("t2_ram12", ram_word(12), 32'hA5B6C7D8);

        // 3. Zero count
        we0 = we_cnt; dn0 = done_cnt; rd0 = rdy_cnt;
        BaseAddr = 8'd40; WordCount = 7'd0; Start = 1'b1;
        tick();
        Start = 1'b0;
        check("t3_done", Done, 1);
        check("t3_busy", Busy, 1);
        check("t3_ready", WordReady, 0);
        tick();
        check("t3_idle_done", Done, 0);
        check("t3_idle_busy", Busy, 0);
        tick();
        check("t3_we_count", we_cnt - we0, 0);
        check("t3_rdy_count", rdy_cnt - rd0, 0);
        check("t3_done_count", done_cnt - dn0, 1);

        // 4. Address wrap
        BaseAddr = 8'd254; WordCount = 7'd1; WordIn = 32'h11223344; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        check("t4_b0_addr", MemAddr, 8'd254);
        check("t4_b0_data", MemData, 8'h11);
        check("t4_b0_wrap", Wrap, 0);
        tick();
        check("t4_b1_addr", MemAddr, 8'd255);
        tick();
        check("t4_b2_addr", MemAddr, 8'd0);
        check("t4_b2_data", MemData, 8'h33);
        check("t4_b2_wrap", Wrap, 1);
        tick();
        check("t4_b3_addr", MemAddr, 8'd1);
        wait_done("t4_done", 20);
        check("t4_wrap_idle", Wrap, 1);
        check("t4_ram254", {24'd0, ram[254]}, 32'h11);
        check("t4_ram255", {24'd0, ram[255]}, 32'h22);
        check("t4_ram0", {24'd0, ram[0]}, 32'h33);
        check("t4_ram1", {24'd0, ram[1]}, 32'h44);

        // 5. Reset mid-load during byte 2, then a clean reload
        BaseAddr = 8'd32; WordCount = 7'd1; WordIn = 32'hCAFEF00D; Start = 1'b1;
        tick();
        Start = 1'b0;
        check("t5_wrap_cleared", Wrap, 0);
        tick(); tick(); tick();
        check("t5_b2_addr", MemAddr, 8'd34);
        check("t5_b2_we", MemWE, 1);
        #2;
        Reset = 1'b0;
        #1;
        check("t5_rst_we", MemWE, 0);
        check("t5_rst_addr", MemAddr, 8'd0);
        check("t5_rst_data", MemData, 8'd0);
        check("t5_rst_busy", Busy, 0);
        check("t5_rst_ready", WordReady, 0);
        check("t5_rst_done", Done, 0);
        tick(); tick();
        Reset = 1'b1;
        tick();
        check("t5_ram33", {24'd0, ram[33]}, 32'hFE);
        check("t5_ram34_unwritten", {24'd0, ram[34]}, 32'hFF);
        dn0 = done_cnt;
        BaseAddr = 8'd16; WordCount = 7'd1; WordIn = 32'h0BADC0DE; Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_done("t5_done", 20);
        check("t5_done_count", done_cnt - dn0, 1);
        check("t5_ram16", ram_word(16), 32'h0BADC0DE);

`ifdef READBACK_VERIFY_EN
        // 6. Readback verify: clean RAM, then a stuck byte at address 5
        BaseAddr = 8'd4; WordCount = 7'd1; WordIn = 32'hAABBCCDD; Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_done("t6_clean_done", 20);
        check("t6_clean_mismatch", Mismatch, 0);
        stuck_en = 1'b1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_done("t6_stuck_done", 20);
        check("t6_stuck_mismatch", Mismatch, 1);
        stuck_en = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("t6_mismatch_cleared", Mismatch, 0);
        wait_done("t6_final_done", 20);
        check("t6_final_mismatch", Mismatch, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
